param_stream_loader: RTL and testbench

//  Synthesisable successor to the file-based CNN/FC/image loader. Accepts a 16-bit word stream

---
 rtl/dcnn_io_pkg.sv | 19 +
 rtl/bit_reverse.sv | 16 +
 rtl/param_stream_loader.sv | 154 +++++++++++++++
 tb/tb_param_stream_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcnn_io_pkg.sv
// Shared types and constants for the parameter stream loader and the accelerator controller.
// Channel indices and default word counts match the on-chip parameter memory map.
package dcnn_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLOSE
    } loader_state_e;

    localparam int unsigned CH_CNN = 0;
    localparam int unsigned CH_FC  = 1;
    localparam int unsigned CH_IMG = 2;

    localparam int unsigned CNN_WORDS = 50704;
    localparam int unsigned FC_WORDS  = 11218;
    localparam int unsigned IMG_WORDS = 1024;

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal: bit i of the result is bit W-1-i of the input.
module bit_reverse #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] data,
    output logic [W-1:0] reversed
);

    always_comb begin
        reversed = '0;
        for (int unsigned i = 0; i < W; i++) begin
            reversed[i] = data[W-1-i];
        end
    end

endmodule

// File: rtl/param_stream_loader.sv
// Streams host words into per-channel parameter memories, one load request at a time,
// and keeps sticky per-channel finish flags plus a global done for the controller.
module param_stream_loader
    import dcnn_io_pkg::*;
#(
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       NUM_CH      = 3,
    parameter logic [NUM_CH-1:0] BITREV_MASK = 3'b100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NUM_CH)-1:0] req_ch,
    input  logic [ADDR_W-1:0]         req_base,
    input  logic [ADDR_W-1:0]         req_len,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic                      abort,
    input  logic                      clear,
    output logic                      wr_en,
    output logic [$clog2(NUM_CH)-1:0] wr_ch,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [NUM_CH-1:0]         finish,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    loader_state_e state, state_next;

    logic [CH_W-1:0]   ch_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] data_rev;

    logic ch_ok;
    logic req_fire;
    logic word_fire;
    logic last_word;
    logic set_finish;
    logic set_err;

    bit_reverse #(.W(DATA_W)) u_bit_reverse (
        .data     (s_data),
        .reversed (data_rev)
    );

    // Zero-extended compare so a power-of-two NUM_CH does not overflow the channel width.
    assign ch_ok     = {1'b0, req_ch} < (CH_W + 1)'(NUM_CH);
    assign req_ready = (state == IDLE);
    assign s_ready   = (state == LOAD) && !abort;
    assign req_fire  = req_valid && req_ready;
    assign word_fire = s_valid && s_ready;
    assign last_word = word_fire && (count == len_r - ADDR_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        set_finish = 1'b0;
        set_err    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    if (!ch_ok) begin
                        set_err = 1'b1;
                    end else if (req_len == '0) begin
                        state_next = CLOSE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    set_err    = 1'b1;
                end else if (last_word) begin
                    state_next = CLOSE;
                end
            end
            CLOSE: begin
                state_next = IDLE;
                if (abort) begin
                    set_err = 1'b1;
                end else begin
                    set_finish = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_r    <= '0;
            base_r  <= '0;
            len_r   <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_ch   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            finish  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= word_fire;

            if (req_fire && ch_ok) begin
                ch_r   <= req_ch;
                base_r <= req_base;
                len_r  <= req_len;
                count  <= '0;
            end else if (word_fire) begin
                count <= count + ADDR_W'(1);
            end

            if (word_fire) begin
                wr_ch   <= ch_r;
                wr_addr <= base_r + count;
                wr_data <= BITREV_MASK[ch_r] ? data_rev : s_data;
            end

            // clear outranks any flag update landing in the same cycle
            if (clear) begin
                finish <= '0;
                done   <= 1'b0;
                err    <= 1'b0;
            end else begin
                if (set_finish) begin
                    finish[ch_r] <= 1'b1;
                end
                done <= &finish;
                if (set_err) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_stream_loader.sv
// Scoreboard bench for param_stream_loader: expected memory writes are queued as words are
// handed over and a separate monitor matches them against the write port every cycle.
module tb_param_stream_loader;
    import dcnn_io_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 2;
    localparam logic [NUM_CH-1:0] REV = 3'b100;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch = '0;
    logic [ADDR_W-1:0] req_base = '0;
    logic [ADDR_W-1:0] req_len = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              abort = 1'b0;
    logic              clear = 1'b0;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_CH-1:0] finish;
    logic              done;
    logic              err;

    wr_t               exp_q[$];
    logic [NUM_CH-1:0] finish_m = '0;
    logic [NUM_CH-1:0] rev_mask = REV;
    logic [DATA_W-1:0] words[$];
    int                checks = 0;
    int                errors = 0;

    param_stream_loader #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NUM_CH      (NUM_CH),
        .BITREV_MASK (REV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ch    (req_ch),
        .req_base  (req_base),
        .req_len   (req_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .abort     (abort),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .finish    (finish),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rev16(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < int'(DATA_W); i++) r[i] = d[DATA_W-1-i];
        return r;
    endfunction

    // Monitor: a word taken at one edge must show up on the write port for exactly the next cycle.
    initial begin
        logic acc;
        wr_t  e;
        acc = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc = 1'b0;
            end else begin
                check("wr_en_timing", wr_en, acc);
                if (wr_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: ch %0d addr %h data %h, none expected",
                                 wr_ch, wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_ch", wr_ch, e.ch);
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                    end
                end
                acc = s_valid && s_ready;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] len);
        bit got;
        got = 1'b0;
        req_valid = 1'b1;
        req_ch    = ch;
        req_base  = base;
        req_len   = len;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!got) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] d, input int unsigned gap);
        bit got;
        got = 1'b0;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back('{ch: ch, addr: addr, data: rev_mask[ch] ? rev16(d) : d});
                got = 1'b1;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!got) check("word_timeout", 32'd0, 32'd1);
    endtask

    // Full load of words[]; checks finish timing and the done lag afterwards.
    task automatic run_load(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] base,
                            input int unsigned max_gap);
        logic [NUM_CH-1:0] prev;
        issue_req(ch, base, ADDR_W'(words.size()));
        for (int i = 0; i < words.size(); i++)
            send_word(ch, base + ADDR_W'(i), words[i], $urandom_range(0, max_gap));
        prev = finish_m;
        check("finish_not_early", finish, prev);
        tick();
        finish_m[ch] = 1'b1;
        check("finish_set", finish, finish_m);
        check("done_lag", done, &prev);
        tick();
        check("done", done, &finish_m);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        finish_m = '0;
        check("clear_finish", finish, 0);
        check("clear_err", err, 0);
        check("clear_done", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_finish", finish, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();
        check("idle_req_ready", req_ready, 1);
        check("idle_s_ready", s_ready, 0);

        // Reset in the middle of a ch0 load.
        issue_req(CH_W'(CH_CNN), 16'h0000, 16'd8);
        for (int i = 0; i < 3; i++) send_word(CH_W'(CH_CNN), ADDR_W'(i), 16'h1000 + DATA_W'(i), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_finish", finish, 0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_finish", finish, 0);

        words = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_load(CH_W'(CH_FC), 16'h0100, 0);
        check("ch1_finish", finish, 3'b010);

        words = '{16'h8001, 16'h0003};
        run_load(CH_W'(CH_IMG), 16'h0000, 0);

        do_clear();
        for (int c = 0; c < 3; c++) begin
            words.delete();
            for (int i = 0; i < 6 - 2 * c; i++) words.push_back(DATA_W'($urandom));
            run_load(CH_W'(c), ADDR_W'($urandom), 3);
        end
        check("all_finish", finish, 3'b111);

        do_clear();
        words.delete();
        run_load(CH_W'(CH_CNN), 16'h1234, 0);

        words = '{16'hAAAA, 16'h5555, 16'h0F0F};
        run_load(CH_W'(CH_FC), 16'hFFFE, 1);

        issue_req(2'd3, 16'h0000, 16'd5);
        check("badch_err", err, 1);
        check("badch_req_ready", req_ready, 1);
        check("badch_s_ready", s_ready, 0);
        repeat (3) tick();
        check("badch_finish", finish, finish_m);

        do_clear();
        issue_req(CH_W'(CH_CNN), 16'h0020, 16'd3);
        send_word(CH_W'(CH_CNN), 16'h0020, 16'h1111, 0);
        send_word(CH_W'(CH_CNN), 16'h0021, 16'h2222, 0);
        s_valid = 1'b1;
        s_data  = 16'h3333;
        abort   = 1'b1;
        @(negedge clk);
        check("abort_s_ready", s_ready, 0);
        tick();
        s_valid = 1'b0;
        abort   = 1'b0;
        check("abort_err", err, 1);
        check("abort_req_ready", req_ready, 1);
        tick();
        check("abort_finish", finish, 0);

        do_clear();
        issue_req(CH_W'(CH_IMG), 16'h0040, 16'd1);
        send_word(CH_W'(CH_IMG), 16'h0040, 16'h00F1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_vs_finish", finish, 0);
        tick();
        check("clear_vs_finish_hold", finish, 0);
        check("clear_vs_finish_done", done, 0);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
